// File: rtl/reg_bank_ab_pkg.sv
// Shared constants for the multicycle MIPS datapath: register numbering,
// stack-pointer reset value and default datapath widths.
package reg_bank_ab_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 5;
   localparam int REG_ZERO       = 0;
   localparam int REG_SP         = 29;
   localparam int SP_RESET_VALUE = 227;

endpackage

// File: rtl/reg_bank_ab_reg_ld.sv
// Loadable register with asynchronous clear; used for the A and B operand latches.
module reg_ld
   import reg_bank_ab_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] q_d;
   logic [DATA_W-1:0] q_q;

   // Next value: take the input when loading, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = d;
      end
   end

   // State register, cleared immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reg_bank_ab.sv
// General register file (32 x DATA_W) with two combinational read ports,
// optional write-to-read forwarding, and the A/B operand latches.
module reg_bank_ab
   import reg_bank_ab_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SP_RESET = SP_RESET_VALUE,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic              a_write,
   input  logic              b_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              zero_write
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              zero_write_q;
   logic              zero_write_d;
   logic              wr_zero;

   assign wr_zero = (write_reg == ADDR_W'(REG_ZERO));

   // Array update: $0 is hard-wired, so writes addressed to it are dropped
   // and flagged instead.
   always_comb begin
      regs_d       = regs_q;
      zero_write_d = 1'b0;
      if (reg_write) begin
         if (wr_zero) begin
            zero_write_d = 1'b1;
         end else begin
            regs_d[write_reg] = write_data;
         end
      end
   end

   // Register array and $0-write flag; reset loads $sp with its start value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (i == REG_SP) ? DATA_W'(SP_RESET) : '0;
         end
         zero_write_q <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         zero_write_q <= zero_write_d;
      end
   end

   // Read ports: $0 reads as zero; a write in flight to the same register
   // is forwarded so the A/B latches can capture it at the same edge.
   always_comb begin
      read_data1 = regs_q[read_reg1];
      read_data2 = regs_q[read_reg2];
      if (read_reg1 == ADDR_W'(REG_ZERO)) begin
         read_data1 = '0;
      end else if ((BYPASS != 0) && reg_write && (write_reg == read_reg1)) begin
         read_data1 = write_data;
      end
      if (read_reg2 == ADDR_W'(REG_ZERO)) begin
         read_data2 = '0;
      end else if ((BYPASS != 0) && reg_write && (write_reg == read_reg2)) begin
         read_data2 = write_data;
      end
   end

   assign zero_write = zero_write_q;

   reg_ld #(.DATA_W(DATA_W)) u_a_latch (
      .clk   (clk),
      .reset (reset),
      .ld    (a_write),
      .d     (read_data1),
      .q     (a_out)
   );

   reg_ld #(.DATA_W(DATA_W)) u_b_latch (
      .clk   (clk),
      .reset (reset),
      .ld    (b_write),
      .d     (read_data2),
      .q     (b_out)
   );

endmodule

// File: tb/tb_reg_bank_ab.sv
// Scoreboard bench for reg_bank_ab: one instance with forwarding, one without,
// sharing the same stimulus.
module tb_reg_bank_ab;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_write = 1'b0;
   logic [4:0]  write_reg = '0;
   logic [31:0] write_data = '0;
   logic [4:0]  read_reg1 = '0;
   logic [4:0]  read_reg2 = '0;
   logic        a_write = 1'b0;
   logic        b_write = 1'b0;

   logic [31:0] rd1, rd2, a_o, b_o;
   logic        zw;
   logic [31:0] rd1_nb, rd2_nb, a_nb, b_nb;
   logic        zw_nb;

   localparam int S_RD1 = 0, S_RD2 = 1, S_A = 2, S_B = 3, S_ZW = 4,
                  S_RD1_NB = 5, S_RD2_NB = 6, S_A_NB = 7, S_B_NB = 8, S_ZW_NB = 9;

   typedef struct {
      int          due;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   reg_bank_ab #(.BYPASS(1)) dut (
      .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .a_write(a_write), .b_write(b_write), .read_data1(rd1), .read_data2(rd2),
      .a_out(a_o), .b_out(b_o), .zero_write(zw)
   );

   reg_bank_ab #(.BYPASS(0)) dut0 (
      .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .a_write(a_write), .b_write(b_write), .read_data1(rd1_nb), .read_data2(rd2_nb),
      .a_out(a_nb), .b_out(b_nb), .zero_write(zw_nb)
   );

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         S_RD1:    return rd1;
         S_RD2:    return rd2;
         S_A:      return a_o;
         S_B:      return b_o;
         S_ZW:     return {31'd0, zw};
         S_RD1_NB: return rd1_nb;
         S_RD2_NB: return rd2_nb;
         S_A_NB:   return a_nb;
         S_B_NB:   return b_nb;
         default:  return {31'd0, zw_nb};
      endcase
   endfunction

   // Expect 'v' on signal 'sel' at the negedge of cycle cyc+ofs.
   task automatic expect_at(input int ofs, input int sel, input logic [31:0] v, input string nm);
      exp_t e;
      e.due  = cyc + ofs;
      e.sel  = sel;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation that has come due.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e   = sb.pop_front();
         act = get_sig(e.sel);
         n_chk++;
         if (act === e.exp) begin
            n_pass++;
         end else begin
            $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, act, e.exp);
         end
      end
   end

   initial begin
      logic [4:0]  hold_addr [5];
      logic [31:0] hold_val  [5];
      hold_addr = '{5'd8, 5'd5, 5'd29, 5'd0, 5'd10};
      hold_val  = '{32'hDEADBEEF, 32'd9, 32'd227, 32'd0, 32'h000000AA};

      // Reset sweep: writes/loads attempted during reset must have no effect.
      for (int i = 0; i < 32; i++) begin
         step();
         reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
         a_write = 1'b1; b_write = 1'b1;
         read_reg1 = 5'(i);
         read_reg2 = 5'(31 - i);
         expect_at(0, S_RD1, (i == 29) ? 32'd227 : 32'd0, "reset_rd1");
         expect_at(0, S_RD2, ((31 - i) == 29) ? 32'd227 : 32'd0, "reset_rd2");
         expect_at(0, S_A, 32'd0, "reset_a");
         expect_at(0, S_B, 32'd0, "reset_b");
         expect_at(0, S_ZW, 32'd0, "reset_zw");
      end
      step();
      reset = 1'b0; reg_write = 1'b0; a_write = 1'b0; b_write = 1'b0;
      read_reg1 = 5'd0; read_reg2 = 5'd0;
      expect_at(0, S_ZW, 32'd0, "post_reset_zw");
      expect_at(0, S_A, 32'd0, "post_reset_a");

      // Write r8, read it back, load A.
      step();
      reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
      step();
      reg_write = 1'b0; read_reg1 = 5'd8;
      expect_at(0, S_RD1, 32'hDEADBEEF, "wr_rd1_r8");
      expect_at(0, S_RD1_NB, 32'hDEADBEEF, "wr_rd1_r8_nb");
      step();
      a_write = 1'b1;
      expect_at(1, S_A, 32'hDEADBEEF, "a_load_r8");
      step();
      a_write = 1'b0;

      // Write to $0: dropped, flagged for exactly one cycle.
      step();
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678; read_reg2 = 5'd0;
      expect_at(0, S_RD2, 32'd0, "r0_rd2_same");
      expect_at(0, S_ZW, 32'd0, "zw_before");
      expect_at(1, S_ZW, 32'd1, "zw_pulse");
      expect_at(1, S_ZW_NB, 32'd1, "zw_pulse_nb");
      step();
      reg_write = 1'b0;
      expect_at(0, S_RD2, 32'd0, "r0_rd2_after");
      expect_at(1, S_ZW, 32'd0, "zw_cleared");

      // Forwarding: r5=7, then write 9 while loading B from r5.
      step();
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'd7;
      step();
      write_data = 32'd9; read_reg2 = 5'd5; b_write = 1'b1;
      expect_at(0, S_RD2, 32'd9, "bypass_rd2");
      expect_at(0, S_RD2_NB, 32'd7, "nobypass_rd2");
      expect_at(1, S_B, 32'd9, "bypass_b");
      expect_at(1, S_B_NB, 32'd7, "nobypass_b");
      step();
      reg_write = 1'b0; b_write = 1'b0;
      expect_at(0, S_RD2, 32'd9, "r5_stored");
      expect_at(0, S_RD2_NB, 32'd9, "r5_stored_nb");

      // Hold: load A with 0xAA (same-edge write), then wander read_reg1.
      step();
      reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h000000AA;
      read_reg1 = 5'd10; a_write = 1'b1;
      expect_at(1, S_A, 32'h000000AA, "a_load_aa");
      expect_at(1, S_A_NB, 32'd0, "a_load_aa_nb");
      step();
      reg_write = 1'b0; a_write = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         read_reg1 = hold_addr[k];
         expect_at(0, S_RD1, hold_val[k], "hold_rd1");
         expect_at(1, S_A, 32'h000000AA, "hold_a");
         expect_at(1, S_A_NB, 32'd0, "hold_a_nb");
      end

      // Asynchronous reset between edges.
      step();
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h55; read_reg1 = 5'd3; a_write = 1'b1;
      step();
      reg_write = 1'b0; a_write = 1'b0;
      expect_at(0, S_RD1, 32'h55, "r3_pre_reset");
      expect_at(0, S_A, 32'h55, "a_pre_reset");
      step();
      read_reg2 = 5'd29;
      #2;
      reset = 1'b1;
      expect_at(0, S_RD1, 32'd0, "async_r3");
      expect_at(0, S_A, 32'd0, "async_a");
      expect_at(0, S_RD2, 32'd227, "async_sp");
      expect_at(0, S_RD1_NB, 32'd0, "async_r3_nb");
      step();
      reset = 1'b0;

      // First write after reset release.
      step();
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h66;
      step();
      reg_write = 1'b0;
      expect_at(0, S_RD1, 32'h66, "post_release_r3");

      repeat (3) step();
      n_chk++;
      if (sb.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
